change_dispenser: RTL and testbench

//  Downstream of the vending FSM: takes a refund/change amount and physically pays it out.

---
 rtl/change_dispenser.sv | 154 +++++++++++++++
 tb/tb_change_dispenser.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: turns one refund request (in 5-units) into a serial train of
// ten/five coin pulses, paying tens first from finite stocks and flagging shortfall.
module change_dispenser #(
    parameter int unsigned AMT_W     = 4,
    parameter int unsigned PULSE_LEN = 2,
    parameter int unsigned GAP_LEN   = 1,
    parameter int unsigned STOCK_W   = 6,
    parameter int unsigned TEN_INIT  = 8,
    parameter int unsigned FIVE_INIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               refund_valid,
    input  logic [AMT_W-1:0]   refund_units,
    output logic               refund_ready,
    input  logic               restock,
    output logic               change10,
    output logic               change5,
    output logic               busy,
    output logic               done,
    output logic               short,
    output logic [STOCK_W-1:0] ten_stock,
    output logic [STOCK_W-1:0] five_stock
);

    localparam int unsigned CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL   = 3'd1,
        PULSE = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state, state_d;
    logic [AMT_W-1:0]   rem, rem_d;
    logic [STOCK_W-1:0] ten_d, five_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               coin_ten, coin_ten_d;
    logic               short_flag, short_flag_d;
    logic               accept;
    logic               change10_d, change5_d, busy_d, done_d, short_d, ready_d;

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rem          <= '0;
            ten_stock    <= STOCK_W'(TEN_INIT);
            five_stock   <= STOCK_W'(FIVE_INIT);
            cnt          <= '0;
            coin_ten     <= 1'b0;
            short_flag   <= 1'b0;
            change10     <= 1'b0;
            change5      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            short        <= 1'b0;
            refund_ready <= 1'b1;
        end else begin
            state        <= state_d;
            rem          <= rem_d;
            ten_stock    <= ten_d;
            five_stock   <= five_d;
            cnt          <= cnt_d;
            coin_ten     <= coin_ten_d;
            short_flag   <= short_flag_d;
            change10     <= change10_d;
            change5      <= change5_d;
            busy         <= busy_d;
            done         <= done_d;
            short        <= short_d;
            refund_ready <= ready_d;
        end
    end

    // Next-state, greedy coin selection and output decode
    always_comb begin
        state_d      = state;
        rem_d        = rem;
        ten_d        = ten_stock;
        five_d       = five_stock;
        cnt_d        = cnt;
        coin_ten_d   = coin_ten;
        short_flag_d = short_flag;
        accept       = (state == IDLE) && refund_valid && refund_ready;

        case (state)
            IDLE: begin
                if (restock) begin
                    ten_d  = STOCK_W'(TEN_INIT);
                    five_d = STOCK_W'(FIVE_INIT);
                end
                if (accept) begin
                    rem_d        = refund_units;
                    short_flag_d = 1'b0;
                    state_d      = SEL;
                end
            end
            SEL: begin
                cnt_d = '0;
                if ((rem > AMT_W'(1)) && (ten_stock != '0)) begin
                    rem_d      = rem - AMT_W'(2);
                    ten_d      = ten_stock - STOCK_W'(1);
                    coin_ten_d = 1'b1;
                    state_d    = PULSE;
                end else if ((rem != '0) && (five_stock != '0)) begin
                    rem_d      = rem - AMT_W'(1);
                    five_d     = five_stock - STOCK_W'(1);
                    coin_ten_d = 1'b0;
                    state_d    = PULSE;
                end else begin
                    // Either paid in full or out of usable coins; leftover is dropped
                    short_flag_d = (rem != '0);
                    rem_d        = '0;
                    state_d      = DONE;
                end
            end
            PULSE: begin
                if (cnt == CNT_W'(PULSE_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = SEL;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the current state one cycle later
        change10_d = (state == PULSE) && coin_ten;
        change5_d  = (state == PULSE) && !coin_ten;
        done_d     = (state == DONE);
        short_d    = (state == DONE) && short_flag;
        ready_d    = (state == IDLE) && !accept;
        busy_d     = !ready_d;
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: three instances with different coin stocks,
// coin pulse trains captured per cycle after the accept edge and compared to hand values.
module tb_change_dispenser;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst          [3];
    logic       refund_valid [3];
    logic [3:0] refund_units [3];
    logic       refund_ready [3];
    logic       restock      [3];
    logic       change10     [3];
    logic       change5      [3];
    logic       busy         [3];
    logic       done         [3];
    logic       short_o      [3];
    logic [5:0] ten_stock    [3];
    logic [5:0] five_stock   [3];

    int n_cmp = 0;
    int n_bad = 0;
    bit overlap_seen = 1'b0;

    change_dispenser #(.TEN_INIT(8), .FIVE_INIT(8)) u_full (
        .clk(clk), .rst(rst[0]), .refund_valid(refund_valid[0]), .refund_units(refund_units[0]),
        .refund_ready(refund_ready[0]), .restock(restock[0]), .change10(change10[0]),
        .change5(change5[0]), .busy(busy[0]), .done(done[0]), .short(short_o[0]),
        .ten_stock(ten_stock[0]), .five_stock(five_stock[0]));

    change_dispenser #(.TEN_INIT(1), .FIVE_INIT(8)) u_one_ten (
        .clk(clk), .rst(rst[1]), .refund_valid(refund_valid[1]), .refund_units(refund_units[1]),
        .refund_ready(refund_ready[1]), .restock(restock[1]), .change10(change10[1]),
        .change5(change5[1]), .busy(busy[1]), .done(done[1]), .short(short_o[1]),
        .ten_stock(ten_stock[1]), .five_stock(five_stock[1]));

    change_dispenser #(.TEN_INIT(1), .FIVE_INIT(0)) u_no_five (
        .clk(clk), .rst(rst[2]), .refund_valid(refund_valid[2]), .refund_units(refund_units[2]),
        .refund_ready(refund_ready[2]), .restock(restock[2]), .change10(change10[2]),
        .change5(change5[2]), .busy(busy[2]), .done(done[2]), .short(short_o[2]),
        .ten_stock(ten_stock[2]), .five_stock(five_stock[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int idx);
        for (int i = 0; i < 50; i++) begin
            if (refund_ready[idx]) break;
            @(posedge clk); #1;
        end
        check("ready_before_req", 32'(refund_ready[idx]), 32'd1);
    endtask

    // Bit n of c10/c5 = output level sampled just after the n-th edge past accept
    task automatic run_refund(input int idx, input logic [3:0] units,
                              output logic [31:0] c10, output logic [31:0] c5,
                              output int done_at, output logic sh);
        c10 = '0; c5 = '0; done_at = -1; sh = 1'b0;
        wait_ready(idx);
        refund_units[idx] = units;
        refund_valid[idx] = 1'b1;
        @(posedge clk); #1;
        refund_valid[idx] = 1'b0;
        for (int n = 1; n < 32; n++) begin
            @(posedge clk); #1;
            c10[n] = change10[idx];
            c5[n]  = change5[idx];
            if (change10[idx] && change5[idx]) overlap_seen = 1'b1;
            if (done[idx]) begin
                done_at = n;
                sh      = short_o[idx];
                break;
            end
        end
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done[idx]), 32'd0);
        check("ready_after_done", 32'(refund_ready[idx]), 32'd1);
    endtask

    logic [31:0] c10, c5;
    int          done_at;
    logic        sh;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; refund_valid[i] = 1'b0; refund_units[i] = '0; restock[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_c10", 32'(change10[0]), 32'd0);
        check("rst_c5", 32'(change5[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_short", 32'(short_o[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_ready", 32'(refund_ready[0]), 32'd1);
        check("rst_ten", 32'(ten_stock[0]), 32'd8);
        check("rst_five", 32'(five_stock[0]), 32'd8);
        check("rst_ten_u1", 32'(ten_stock[1]), 32'd1);
        check("rst_five_u2", 32'(five_stock[2]), 32'd0);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        @(posedge clk); #1;

        // Refund 3: ten then five, 4-cycle coin period
        run_refund(0, 4'd3, c10, c5, done_at, sh);
        check("r3_c10", c10, 32'h0000_000C);
        check("r3_c5", c5, 32'h0000_00C0);
        check("r3_done_at", 32'(done_at), 32'd10);
        check("r3_short", 32'(sh), 32'd0);
        check("r3_ten", 32'(ten_stock[0]), 32'd7);
        check("r3_five", 32'(five_stock[0]), 32'd7);

        // Refund 0: no coins, done two edges after accept
        run_refund(0, 4'd0, c10, c5, done_at, sh);
        check("r0_c10", c10, 32'h0);
        check("r0_c5", c5, 32'h0);
        check("r0_done_at", 32'(done_at), 32'd2);
        check("r0_short", 32'(sh), 32'd0);
        check("r0_ten", 32'(ten_stock[0]), 32'd7);
        check("r0_five", 32'(five_stock[0]), 32'd7);

        // One ten in stock, refund 4: ten then two fives
        run_refund(1, 4'd4, c10, c5, done_at, sh);
        check("r4_c10", c10, 32'h0000_000C);
        check("r4_c5", c5, 32'h0000_0CC0);
        check("r4_done_at", 32'(done_at), 32'd14);
        check("r4_short", 32'(sh), 32'd0);
        check("r4_ten", 32'(ten_stock[1]), 32'd0);
        check("r4_five", 32'(five_stock[1]), 32'd6);

        // One ten, no fives, refund 3: shortfall after the ten
        run_refund(2, 4'd3, c10, c5, done_at, sh);
        check("sh_c10", c10, 32'h0000_000C);
        check("sh_c5", c5, 32'h0);
        check("sh_done_at", 32'(done_at), 32'd6);
        check("sh_short", 32'(sh), 32'd1);
        check("sh_ten", 32'(ten_stock[2]), 32'd0);
        check("sh_five", 32'(five_stock[2]), 32'd0);
        restock[2] = 1'b1;
        @(posedge clk); #1;
        restock[2] = 1'b0;
        check("restock_ten", 32'(ten_stock[2]), 32'd1);
        check("restock_five", 32'(five_stock[2]), 32'd0);

        // Requests and restock while busy are ignored; reset mid pulse
        wait_ready(0);
        refund_units[0] = 4'd3;
        refund_valid[0] = 1'b1;
        @(posedge clk); #1;
        refund_units[0] = 4'd5;
        restock[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_c10_on", 32'(change10[0]), 32'd1);
        check("busy_ready", 32'(refund_ready[0]), 32'd0);
        check("busy_flag", 32'(busy[0]), 32'd1);
        @(posedge clk); #1;
        check("busy_restock_ignored", 32'(ten_stock[0]), 32'd6);
        check("busy_c10_still", 32'(change10[0]), 32'd1);
        rst[0] = 1'b1;
        refund_valid[0] = 1'b0;
        restock[0] = 1'b0;
        #1;
        check("midrst_c10_drop", 32'(change10[0]), 32'd0);
        check("midrst_ten", 32'(ten_stock[0]), 32'd8);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(refund_ready[0]), 32'd1);
        check("post_rst_busy", 32'(busy[0]), 32'd0);
        check("post_rst_ten", 32'(ten_stock[0]), 32'd8);
        check("post_rst_five", 32'(five_stock[0]), 32'd8);

        check("coin_overlap", 32'(overlap_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
